// File: rtl/add_station_if.sv
// add_station_if: allocation, result-bus snoop and result handshake signals
// of the adder reservation station. master = driver side, slave = station.
interface add_station_if #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 4,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int NUM_BUS = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                      flush;
  logic                      alloc_valid;
  logic                      alloc_ready;
  logic [TAG_W-1:0]          alloc_tag;
  logic [REG_W-1:0]          alloc_reg;
  logic [3:0]                alloc_op;
  logic [DATA_W-1:0]         alloc_v0;
  logic [DATA_W-1:0]         alloc_v1;
  logic                      alloc_rdy0;
  logic                      alloc_rdy1;
  logic [TAG_W-1:0]          alloc_src0;
  logic [TAG_W-1:0]          alloc_src1;
  logic [CNT_W-1:0]          free_count;
  logic [NUM_BUS-1:0]        bus_valid;
  logic [NUM_BUS*TAG_W-1:0]  bus_tag;
  logic [NUM_BUS*DATA_W-1:0] bus_data;
  logic                      res_valid;
  logic                      res_ready;
  logic [DATA_W-1:0]         res_data;
  logic [TAG_W-1:0]          res_tag;
  logic [REG_W-1:0]          res_reg;
  logic                      res_is_jeq;
  logic                      res_jeq_taken;

  modport master (
    output flush, alloc_valid, alloc_reg, alloc_op, alloc_v0, alloc_v1,
           alloc_rdy0, alloc_rdy1, alloc_src0, alloc_src1,
           bus_valid, bus_tag, bus_data, res_ready,
    input  alloc_ready, alloc_tag, free_count,
           res_valid, res_data, res_tag, res_reg, res_is_jeq, res_jeq_taken
  );

  modport slave (
    input  flush, alloc_valid, alloc_reg, alloc_op, alloc_v0, alloc_v1,
           alloc_rdy0, alloc_rdy1, alloc_src0, alloc_src1,
           bus_valid, bus_tag, bus_data, res_ready,
    output alloc_ready, alloc_tag, free_count,
           res_valid, res_data, res_tag, res_reg, res_is_jeq, res_jeq_taken
  );
endinterface

// File: rtl/add_station_array.sv
// add_station_array: DEPTH-entry adder reservation station snooping NUM_BUS
// result buses, issuing one ready entry per cycle round-robin into a
// registered result stage with valid/ready back-pressure.
// Optional compare opcode (6) is enabled by defining ADD_RS_JEQ_EN.
module add_station_array #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 4,
  parameter int REG_W    = 4,
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 0,
  parameter int NUM_BUS  = 2
) (
  input logic          clk,
  input logic          rst,
  add_station_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [TAG_W-1:0] NO_TAG = '1;
`ifdef ADD_RS_JEQ_EN
  localparam bit JEQ_EN = 1'b1;
`else
  localparam bit JEQ_EN = 1'b0;
`endif

  // Modulo 2^DATA_W add; the carry is intentionally dropped.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Returns {is_jeq, taken, data} for one operation.
  function automatic logic [DATA_W+1:0] alu(input logic [3:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    if (JEQ_EN && (op == 4'd6)) return {1'b1, (a == b), a};
    return {2'b00, wrap_add(a, b)};
  endfunction

  // Bus match for one source tag: {hit, data}; lowest bus index wins.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0]          tag,
                                            input logic [NUM_BUS-1:0]        bv,
                                            input logic [NUM_BUS*TAG_W-1:0]  bt,
                                            input logic [NUM_BUS*DATA_W-1:0] bd);
    logic [DATA_W:0] r;
    r = '0;
    if (tag != NO_TAG) begin
      for (int k = NUM_BUS - 1; k >= 0; k--) begin
        if (bv[k] && (bt[k*TAG_W +: TAG_W] == tag)) r = {1'b1, bd[k*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Entry storage
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  rdy0;
  logic [DEPTH-1:0]  rdy1;
  logic [REG_W-1:0]  ent_reg  [DEPTH];
  logic [3:0]        ent_op   [DEPTH];
  logic [DATA_W-1:0] ent_v0   [DEPTH];
  logic [DATA_W-1:0] ent_v1   [DEPTH];
  logic [TAG_W-1:0]  ent_src0 [DEPTH];
  logic [TAG_W-1:0]  ent_src1 [DEPTH];
  logic [IDX_W-1:0]  rr_ptr;

  // Issue-side combinational signals
  logic [DEPTH-1:0]  ready_vec;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic [CNT_W-1:0]  free_cnt;
  logic              alloc_fire;
  logic              load;
  logic              direct;
  logic [DATA_W:0]   a0_snp;
  logic [DATA_W:0]   a1_snp;
  logic              a0_rdy;
  logic              a1_rdy;
  logic [DATA_W-1:0] a0_val;
  logic [DATA_W-1:0] a1_val;
  logic [DEPTH-1:0]  w0_hit;
  logic [DEPTH-1:0]  w1_hit;
  logic [DATA_W-1:0] w0_data [DEPTH];
  logic [DATA_W-1:0] w1_data [DEPTH];

  logic [TAG_W-1:0]  iss_tag_p0;
  logic [REG_W-1:0]  iss_reg_p0;
  logic [3:0]        iss_op_p0;
  logic [DATA_W-1:0] iss_v0_p0;
  logic [DATA_W-1:0] iss_v1_p0;
  logic [DATA_W+1:0] alu_p0;

  logic              res_valid_p1;
  logic [DATA_W-1:0] res_data_p1;
  logic [TAG_W-1:0]  res_tag_p1;
  logic [REG_W-1:0]  res_reg_p1;
  logic              res_jeq_p1;
  logic              res_taken_p1;

  assign ready_vec = busy & rdy0 & rdy1;

  // Round-robin pick: first ready entry at or after rr_ptr, wrapping.
  always_comb begin
    int p;
    sel_found = 1'b0;
    sel_idx   = '0;
    p         = 0;
    for (int k = 0; k < DEPTH; k++) begin
      p = int'(rr_ptr) + k;
      if (p >= DEPTH) p = p - DEPTH;
      if (!sel_found && ready_vec[p]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(p);
      end
    end
  end

  // Lowest free entry and free-entry count from the current busy state.
  always_comb begin
    free_idx = '0;
    free_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
      free_cnt = free_cnt + CNT_W'(!busy[i]);
    end
  end

  assign rs.alloc_ready = ~&busy;
  assign rs.alloc_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign rs.free_count  = free_cnt;

  // Allocation-time bus bypass for operands that are not yet ready.
  always_comb begin
    a0_snp = snoop(rs.alloc_src0, rs.bus_valid, rs.bus_tag, rs.bus_data);
    a1_snp = snoop(rs.alloc_src1, rs.bus_valid, rs.bus_tag, rs.bus_data);
    a0_rdy = rs.alloc_rdy0 | a0_snp[DATA_W];
    a1_rdy = rs.alloc_rdy1 | a1_snp[DATA_W];
    a0_val = rs.alloc_rdy0 ? rs.alloc_v0 : a0_snp[DATA_W-1:0];
    a1_val = rs.alloc_rdy1 ? rs.alloc_v1 : a1_snp[DATA_W-1:0];
  end

  // Wakeup matches for every stored source tag.
  always_comb begin
    w0_hit = '0;
    w1_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {w0_hit[i], w0_data[i]} = snoop(ent_src0[i], rs.bus_valid, rs.bus_tag, rs.bus_data);
      {w1_hit[i], w1_data[i]} = snoop(ent_src1[i], rs.bus_valid, rs.bus_tag, rs.bus_data);
    end
  end

  // A fully-ready allocation with nothing else eligible goes straight to the
  // result stage, giving one-cycle allocate-to-result latency.
  assign alloc_fire = rs.alloc_valid & rs.alloc_ready & ~rs.flush;
  assign load       = ~res_valid_p1 | rs.res_ready;
  assign direct     = load & ~sel_found & alloc_fire & a0_rdy & a1_rdy;

  // ---- stage p0: issue operand mux and ALU ----
  always_comb begin
    if (sel_found) begin
      iss_tag_p0 = TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
      iss_reg_p0 = ent_reg[sel_idx];
      iss_op_p0  = ent_op[sel_idx];
      iss_v0_p0  = ent_v0[sel_idx];
      iss_v1_p0  = ent_v1[sel_idx];
    end else begin
      iss_tag_p0 = rs.alloc_tag;
      iss_reg_p0 = rs.alloc_reg;
      iss_op_p0  = rs.alloc_op;
      iss_v0_p0  = a0_val;
      iss_v1_p0  = a1_val;
    end
    alu_p0 = alu(iss_op_p0, iss_v0_p0, iss_v1_p0);
  end

  // ---- stage p1: result register, busy bits and round-robin pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      rr_ptr       <= '0;
      res_valid_p1 <= 1'b0;
      res_data_p1  <= '0;
      res_tag_p1   <= NO_TAG;
      res_reg_p1   <= '0;
      res_jeq_p1   <= 1'b0;
      res_taken_p1 <= 1'b0;
    end else if (rs.flush) begin
      busy         <= '0;
      rr_ptr       <= '0;
      res_valid_p1 <= 1'b0;
    end else begin
      if (load) begin
        if (sel_found || direct) begin
          res_valid_p1 <= 1'b1;
          res_data_p1  <= alu_p0[DATA_W-1:0];
          res_taken_p1 <= alu_p0[DATA_W];
          res_jeq_p1   <= alu_p0[DATA_W+1];
          res_tag_p1   <= iss_tag_p0;
          res_reg_p1   <= iss_reg_p0;
          rr_ptr       <= next_idx(sel_found ? sel_idx : free_idx);
          if (sel_found) busy[sel_idx] <= 1'b0;
        end else begin
          res_valid_p1 <= 1'b0;
        end
      end
      if (alloc_fire && !direct) busy[free_idx] <= 1'b1;
    end
  end

  // Entry payload: allocation writes and bus wakeup captures.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_fire && !direct && (free_idx == IDX_W'(i))) begin
        ent_reg[i]  <= rs.alloc_reg;
        ent_op[i]   <= rs.alloc_op;
        ent_v0[i]   <= a0_val;
        ent_v1[i]   <= a1_val;
        rdy0[i]     <= a0_rdy;
        rdy1[i]     <= a1_rdy;
        ent_src0[i] <= a0_rdy ? NO_TAG : rs.alloc_src0;
        ent_src1[i] <= a1_rdy ? NO_TAG : rs.alloc_src1;
      end else if (busy[i]) begin
        if (!rdy0[i] && w0_hit[i]) begin
          ent_v0[i]   <= w0_data[i];
          rdy0[i]     <= 1'b1;
          ent_src0[i] <= NO_TAG;
        end
        if (!rdy1[i] && w1_hit[i]) begin
          ent_v1[i]   <= w1_data[i];
          rdy1[i]     <= 1'b1;
          ent_src1[i] <= NO_TAG;
        end
      end
    end
  end

  assign rs.res_valid     = res_valid_p1;
  assign rs.res_data      = res_data_p1;
  assign rs.res_tag       = res_tag_p1;
  assign rs.res_reg       = res_reg_p1;
  assign rs.res_is_jeq    = res_jeq_p1;
  assign rs.res_jeq_taken = res_taken_p1;
endmodule

// File: tb/tb_add_station_array.sv
// tb_add_station_array: directed bench with a reservation-station model and
// a per-cycle compare process for add_station_array.
module tb_add_station_array;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 4;
  localparam int REG_W    = 4;
  localparam int DEPTH    = 4;
  localparam int TAG_BASE = 0;
  localparam int NUM_BUS  = 2;
`ifdef ADD_RS_JEQ_EN
  localparam bit JEQ_EN = 1'b1;
`else
  localparam bit JEQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_station_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .REG_W(REG_W),
                   .DEPTH(DEPTH), .NUM_BUS(NUM_BUS)) bus_if ();

  add_station_array #(.DATA_W(DATA_W), .TAG_W(TAG_W), .REG_W(REG_W), .DEPTH(DEPTH),
                      .TAG_BASE(TAG_BASE), .NUM_BUS(NUM_BUS))
    dut (.clk(clk), .rst(rst), .rs(bus_if));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_busy [DEPTH];
  logic [3:0]  m_reg  [DEPTH];
  logic [3:0]  m_op   [DEPTH];
  logic [15:0] m_v0   [DEPTH];
  logic [15:0] m_v1   [DEPTH];
  bit          m_r0   [DEPTH];
  bit          m_r1   [DEPTH];
  logic [3:0]  m_s0   [DEPTH];
  logic [3:0]  m_s1   [DEPTH];
  int          m_rr;
  bit          m_rv;
  logic [15:0] m_rdata;
  logic [3:0]  m_rtag;
  logic [3:0]  m_rreg;
  bit          m_rjeq;
  bit          m_rtaken;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    m_rr = 0; m_rv = 1'b0; m_rdata = '0; m_rtag = 4'hF; m_rreg = '0;
    m_rjeq = 1'b0; m_rtaken = 1'b0;
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  task automatic lookup(input logic [3:0] tag, output bit hit, output logic [15:0] d);
    hit = 1'b0; d = '0;
    if (tag != 4'hF)
      for (int k = 0; k < NUM_BUS; k++)
        if (!hit && bus_if.bus_valid[k] && bus_if.bus_tag[k*TAG_W +: TAG_W] == tag) begin
          hit = 1'b1;
          d = bus_if.bus_data[k*DATA_W +: DATA_W];
        end
  endtask

  task automatic model_result(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input int idx, input logic [3:0] rg);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    m_rv = 1'b1; m_rtag = 4'(TAG_BASE + idx); m_rreg = rg;
    if (JEQ_EN && op == 4'd6) begin
      m_rjeq = 1'b1; m_rtaken = (a == b); m_rdata = a;
    end else begin
      m_rjeq = 1'b0; m_rtaken = 1'b0; m_rdata = s[15:0];
    end
  endtask

  // Advance the model by one clock edge from the currently driven inputs.
  task automatic model_step();
    int sel, fr, p;
    bit fire, load, direct, h, a0r, a1r;
    logic [15:0] d, a0, a1;
    if (rst) begin model_reset(); return; end
    if (bus_if.flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_rv = 1'b0; m_rr = 0;
      return;
    end
    sel = -1;
    for (int k = 0; k < DEPTH; k++) begin
      p = (m_rr + k) % DEPTH;
      if (sel < 0 && m_busy[p] && m_r0[p] && m_r1[p]) sel = p;
    end
    fr = -1;
    for (int i = 0; i < DEPTH; i++) if (fr < 0 && !m_busy[i]) fr = i;
    fire = bus_if.alloc_valid && (fr >= 0);
    a0r = bus_if.alloc_rdy0; a0 = bus_if.alloc_v0;
    if (!a0r) begin lookup(bus_if.alloc_src0, h, d); if (h) begin a0r = 1'b1; a0 = d; end end
    a1r = bus_if.alloc_rdy1; a1 = bus_if.alloc_v1;
    if (!a1r) begin lookup(bus_if.alloc_src1, h, d); if (h) begin a1r = 1'b1; a1 = d; end end
    load   = !m_rv || bus_if.res_ready;
    direct = load && (sel < 0) && fire && a0r && a1r;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && !m_r0[i]) begin
        lookup(m_s0[i], h, d);
        if (h) begin m_r0[i] = 1'b1; m_v0[i] = d; m_s0[i] = 4'hF; end
      end
      if (m_busy[i] && !m_r1[i]) begin
        lookup(m_s1[i], h, d);
        if (h) begin m_r1[i] = 1'b1; m_v1[i] = d; m_s1[i] = 4'hF; end
      end
    end
    if (load) begin
      if (sel >= 0) begin
        model_result(m_op[sel], m_v0[sel], m_v1[sel], sel, m_reg[sel]);
        m_busy[sel] = 1'b0;
        m_rr = (sel + 1) % DEPTH;
      end else if (direct) begin
        model_result(bus_if.alloc_op, a0, a1, fr, bus_if.alloc_reg);
        m_rr = (fr + 1) % DEPTH;
      end else begin
        m_rv = 1'b0;
      end
    end
    if (fire && !direct) begin
      m_busy[fr] = 1'b1; m_reg[fr] = bus_if.alloc_reg; m_op[fr] = bus_if.alloc_op;
      m_v0[fr] = a0; m_r0[fr] = a0r; m_s0[fr] = a0r ? 4'hF : bus_if.alloc_src0;
      m_v1[fr] = a1; m_r1[fr] = a1r; m_s1[fr] = a1r ? 4'hF : bus_if.alloc_src1;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("res_valid", bus_if.res_valid, m_rv);
      if (m_rv) begin
        check("res_data", bus_if.res_data, m_rdata);
        check("res_tag", bus_if.res_tag, m_rtag);
        check("res_reg", bus_if.res_reg, m_rreg);
        check("res_is_jeq", bus_if.res_is_jeq, m_rjeq);
        check("res_jeq_taken", bus_if.res_jeq_taken, m_rtaken);
      end
      check("free_count", bus_if.free_count, m_free());
      check("alloc_ready", bus_if.alloc_ready, m_free() > 0);
      if (m_free() > 0) check("alloc_tag", bus_if.alloc_tag, TAG_BASE + m_first_free());
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.alloc_valid = 1'b0;
    bus_if.bus_valid   = '0;
    bus_if.flush       = 1'b0;
  endtask

  task automatic set_alloc(input logic [3:0] rg, input logic [3:0] op,
                           input logic [15:0] v0, input logic [15:0] v1,
                           input bit r0, input bit r1, input logic [3:0] s0, input logic [3:0] s1);
    bus_if.alloc_valid = 1'b1; bus_if.alloc_reg = rg; bus_if.alloc_op = op;
    bus_if.alloc_v0 = v0; bus_if.alloc_v1 = v1;
    bus_if.alloc_rdy0 = r0; bus_if.alloc_rdy1 = r1;
    bus_if.alloc_src0 = s0; bus_if.alloc_src1 = s1;
  endtask

  task automatic set_bus(input int k, input logic [3:0] tag, input logic [15:0] d);
    bus_if.bus_valid[k] = 1'b1;
    bus_if.bus_tag[k*TAG_W +: TAG_W] = tag;
    bus_if.bus_data[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.flush = 1'b0; bus_if.alloc_valid = 1'b0; bus_if.alloc_reg = '0; bus_if.alloc_op = '0;
    bus_if.alloc_v0 = '0; bus_if.alloc_v1 = '0; bus_if.alloc_rdy0 = 1'b0; bus_if.alloc_rdy1 = 1'b0;
    bus_if.alloc_src0 = 4'hF; bus_if.alloc_src1 = 4'hF;
    bus_if.bus_valid = '0; bus_if.bus_tag = '0; bus_if.bus_data = '0; bus_if.res_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset values
    check("rst_res_valid", bus_if.res_valid, 0);
    check("rst_res_tag", bus_if.res_tag, 4'hF);
    check("rst_res_data", bus_if.res_data, 0);
    check("rst_free_count", bus_if.free_count, 4);
    check("rst_alloc_tag", bus_if.alloc_tag, TAG_BASE);

    // Both operands ready: result the next cycle
    set_alloc(4'd3, 4'd1, 16'h0005, 16'h0007, 1, 1, 4'hF, 4'hF);
    bus_if.res_ready = 1'b1;
    tick(); idle();
    check("add_valid", bus_if.res_valid, 1);
    check("add_data", bus_if.res_data, 16'h000C);
    check("add_reg", bus_if.res_reg, 3);
    check("add_tag", bus_if.res_tag, TAG_BASE);
    check("add_free", bus_if.free_count, 4);
    tick();
    check("add_drained", bus_if.res_valid, 0);

    // Wakeup from bus1 two cycles after allocation
    check("wk_alloc_tag", bus_if.alloc_tag, 0);
    set_alloc(4'd2, 4'd1, 16'h0000, 16'h0001, 0, 1, 4'd9, 4'hF);
    tick(); idle();
    check("wk_free", bus_if.free_count, 3);
    tick();
    set_bus(1, 4'd9, 16'h1234);
    tick(); idle();
    check("wk_not_yet", bus_if.res_valid, 0);
    tick();
    check("wk_valid", bus_if.res_valid, 1);
    check("wk_data", bus_if.res_data, 16'h1235);
    tick();

    // Duplicate tag on both buses: bus0 wins
    set_alloc(4'd2, 4'd1, 16'h0000, 16'h0001, 0, 1, 4'd9, 4'hF);
    tick(); idle();
    set_bus(0, 4'd9, 16'hAAAA);
    set_bus(1, 4'd9, 16'h1234);
    tick(); idle();
    tick();
    check("dup_data", bus_if.res_data, 16'hAAAB);
    tick();

    // Fill, overflow attempt, wake all, hold, drain in order
    bus_if.flush = 1'b1;
    tick(); idle();
    bus_if.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_alloc(4'(4 + i), 4'd1, 16'h0000, 16'(i + 1), 0, 1, 4'd10, 4'hF);
      tick();
    end
    idle();
    check("full_ready", bus_if.alloc_ready, 0);
    check("full_free", bus_if.free_count, 0);
    set_alloc(4'd9, 4'd1, 16'h0001, 16'h0001, 1, 1, 4'hF, 4'hF);
    tick(); idle();
    check("full_ignored", bus_if.free_count, 0);
    set_bus(0, 4'd10, 16'h0100);
    tick(); idle();
    tick();
    check("hold_tag0", bus_if.res_tag, 0);
    check("hold_data0", bus_if.res_data, 16'h0101);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("hold_stable_tag", bus_if.res_tag, 0);
      check("hold_stable_data", bus_if.res_data, 16'h0101);
    end
    bus_if.res_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("drain_tag", bus_if.res_tag, i);
      check("drain_data", bus_if.res_data, 16'h0101 + 16'(i));
    end
    tick();
    check("drain_empty", bus_if.res_valid, 0);
    check("drain_free", bus_if.free_count, 4);

    // Modulo add
    set_alloc(4'd5, 4'd1, 16'hFFFF, 16'h0002, 1, 1, 4'hF, 4'hF);
    tick(); idle();
    check("wrap_data", bus_if.res_data, 16'h0001);
    tick();

    // Opcode 6
    set_alloc(4'd6, 4'd6, 16'h00AA, 16'h00AA, 1, 1, 4'hF, 4'hF);
    tick(); idle();
    check("op6_jeq", bus_if.res_is_jeq, JEQ_EN);
    check("op6_taken", bus_if.res_jeq_taken, JEQ_EN);
    check("op6_data", bus_if.res_data, JEQ_EN ? 16'h00AA : 16'h0154);
    tick();
    set_alloc(4'd6, 4'd6, 16'h00AA, 16'h00AB, 1, 1, 4'hF, 4'hF);
    tick(); idle();
    check("op6ne_taken", bus_if.res_jeq_taken, 0);
    check("op6ne_data", bus_if.res_data, JEQ_EN ? 16'h00AA : 16'h0155);
    tick();

    // Flush with 3 busy entries and a held result
    bus_if.res_ready = 1'b0;
    set_alloc(4'd1, 4'd1, 16'h0001, 16'h0002, 1, 1, 4'hF, 4'hF);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_alloc(4'd7, 4'd1, 16'h0000, 16'h0000, 0, 0, 4'(12 + i), 4'(12 + i));
      tick();
    end
    idle();
    check("pre_flush_free", bus_if.free_count, 1);
    check("pre_flush_data", bus_if.res_data, 16'h0003);
    bus_if.flush = 1'b1;
    tick(); idle();
    check("flush_valid", bus_if.res_valid, 0);
    check("flush_free", bus_if.free_count, 4);
    check("flush_tag", bus_if.alloc_tag, TAG_BASE);
    set_bus(0, 4'd12, 16'h0001);
    set_bus(1, 4'd13, 16'h0002);
    tick(); idle();
    tick(); tick();
    check("flush_stale", bus_if.res_valid, 0);

    // Asynchronous reset with 3 busy entries and a held result
    set_alloc(4'd1, 4'd1, 16'h0001, 16'h0002, 1, 1, 4'hF, 4'hF);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_alloc(4'd7, 4'd1, 16'h0000, 16'h0000, 0, 0, 4'(12 + i), 4'(12 + i));
      tick();
    end
    idle();
    check("pre_rst_valid", bus_if.res_valid, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_valid", bus_if.res_valid, 0);
    check("rst_async_free", bus_if.free_count, 4);
    check("rst_async_tag", bus_if.alloc_tag, TAG_BASE);
    check("rst_async_rtag", bus_if.res_tag, 4'hF);
    tick();
    rst = 1'b0;
    set_bus(0, 4'd12, 16'h0001);
    set_bus(1, 4'd14, 16'h0002);
    tick(); idle();
    tick(); tick();
    check("rst_stale", bus_if.res_valid, 0);
    check("rst_stale_free", bus_if.free_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_station_array.md
# add_station_array

Parametrised adder reservation station for the Tomasulo back end. It holds up to DEPTH add/compare operations and captures missing operands by snooping NUM_BUS result buses. It issues one ready entry per cycle, round-robin, into a registered result stage that drains to the common-bus arbiter under a valid/ready handshake. It replaces the fixed two-entry, single-bus adder station, adding configurable depth and bus count, back-pressure, flush, and reset.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- TAG_W, 4, producer tag width; tag all-ones = "no producer"
- REG_W, 4, destination register index width
- DEPTH, 4, entry count (2..8); entry i owns tag TAG_BASE+i
- TAG_BASE, 0, first tag owned; TAG_BASE+DEPTH-1 < 2^TAG_W-1
- NUM_BUS, 2, snooped result buses

Ports:
- clk in 1 clock, rising edge
- rst in 1 reset, asynchronous, active-high
- flush in 1 discard all entries and result stage
- alloc_valid in 1 allocation request
- alloc_ready out 1 at least one free entry
- alloc_tag out TAG_W tag of entry that would be allocated now
- alloc_reg in REG_W destination register
- alloc_op in 4 opcode: 1,5 add; 6 jeq; others add
- alloc_v0, alloc_v1 in DATA_W operand values
- alloc_rdy0, alloc_rdy1 in 1 operand value valid
- alloc_src0, alloc_src1 in TAG_W producer tag when not ready
- free_count out $clog2(DEPTH)+1 free entries
- bus_valid in NUM_BUS per-bus broadcast valid
- bus_tag in NUM_BUS*TAG_W packed, bus k at [k*TAG_W +: TAG_W]
- bus_data in NUM_BUS*DATA_W packed likewise
- res_valid out 1 result stage full
- res_ready in 1 arbiter accepts result
- res_data out DATA_W sum (add) or v0 (jeq)
- res_tag out TAG_W tag of issuing entry
- res_reg out REG_W destination register
- res_is_jeq out 1 result is a compare
- res_jeq_taken out 1 v0 == v1 (jeq only)

## Operation
- Entry fields: busy, reg, op, v0/rdy0/src0, v1/rdy1/src1. Ready = busy & rdy0 & rdy1.
- Allocation: on alloc_valid & alloc_ready, write the lowest-index free entry (index given by alloc_tag). Ignore alloc_valid while alloc_ready=0.
- Allocation bypass: if a not-ready source tag matches a bus broadcasting this cycle, the entry is written with the bus data and rdy=1.
- Wakeup: for each busy entry operand with rdy=0, if bus k is valid and its tag equals src, capture the data, set rdy=1, and set src to all-ones. Lowest k wins on duplicate tags. Tag all-ones never matches.
- Issue: the result stage loads when empty or draining (res_valid & res_ready). Select the first ready entry at or after rr_ptr, wrapping. Then rr_ptr = selected+1 mod DEPTH, and the entry is freed at the same edge.
- Arithmetic: add is modulo 2^DATA_W, carry dropped. Jeq sets res_jeq_taken = (v0==v1) and res_data = v0.
- An entry freed this cycle is not allocatable until the next cycle; alloc_ready/alloc_tag use the current busy state.
- flush (synchronous, top priority): clear all busy bits and res_valid, and set rr_ptr to 0. Same-cycle alloc and issue are dropped.
- Result stage holds all res_* outputs stable while res_valid & !res_ready.

## Timing
- Reset values: all entries not busy; rr_ptr 0; res_valid 0; res_data 0; res_tag all-ones; res_reg 0; res_is_jeq 0; res_jeq_taken 0; alloc_ready 1; alloc_tag TAG_BASE; free_count DEPTH.
- Reset asserted mid-operation clears state immediately (asynchronous) with no partial result.
- Latency:
  - Allocation with both operands ready in cycle t: res_valid in t+1, assuming the stage is free and no older ready entry is ahead under round-robin.
  - Wakeup by a bus in cycle t: entry eligible in t+1, result at t+2.
- Full throughput is one result per cycle while res_ready=1.
- Full (free_count=0): alloc_ready=0.
- Empty: res_valid falls once drained.
- free_count reflects state after the last edge.

## Configuration
- ADD_RS_JEQ_EN defined: opcode 6 performs compare as above.
- Undefined: opcode 6 is treated as add, and res_is_jeq and res_jeq_taken are tied 0.

## Test plan
- Reset, then alloc reg=3 op=1 v0=0x0005 v1=0x0007 both ready, with res_ready=1:
  - next cycle res_valid=1, res_data=0x000C, res_reg=3, res_tag=TAG_BASE.
  - free_count returns to 4.
- Alloc entry 0 with src0=9 not ready. Bus1 broadcasts tag 9 data 0x1234 two cycles later:
  - result 0x1234+v1 appears two cycles after the broadcast.
  - A simultaneous bus0 tag 9 data 0xAAAA overrides bus1.
- Fill all 4 entries not ready:
  - alloc_ready=0, and a fifth alloc_valid is ignored.
  - Wake all in one cycle with res_ready held 0 for 3 cycles: res_* stays stable, then results drain in order 0,1,2,3 at one per cycle.
- Operands 0xFFFF + 0x0002: res_data=0x0001.
- With ADD_RS_JEQ_EN, op=6 v0=v1=0x00AA: res_is_jeq=1, res_jeq_taken=1. With v1=0x00AB: res_jeq_taken=0.
- Flush, or assert rst, while 3 entries are busy and res_valid=1:
  - next cycle res_valid=0, free_count=4, alloc_tag=TAG_BASE.
  - Stale bus tags no longer wake any entry.
